// File: rtl/layer_seq_ctrl.sv
// Sequences NUM_LAYERS layer engines in order behind one start/busy/done handshake.
// Optional per-layer watchdog with an ERROR state is enabled by defining LAYER_SEQ_WATCHDOG_EN.
module layer_seq_ctrl #(
  parameter int NUM_LAYERS = 3,
  parameter int IDX_W      = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [IDX_W-1:0]      cur_layer,
  output logic [CNT_W-1:0]      run_cycles,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_FINISH = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] layer_nxt;
  logic             cur_done;
  logic             run_accept;

`ifdef LAYER_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
`endif

  assign cur_done   = layer_done[cur_layer];
  assign run_accept = (state_nxt == S_LAUNCH) && (state == S_IDLE || state == S_ERROR);

  always_comb begin
    state_nxt = state;
    layer_nxt = cur_layer;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LAUNCH;
          layer_nxt = '0;
        end
      end
      S_LAUNCH: begin
        if (abort) begin
          state_nxt = S_IDLE;
          layer_nxt = '0;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
          layer_nxt = '0;
        end else if (cur_done) begin
          if (cur_layer == LAST_IDX) begin
            state_nxt = S_FINISH;
          end else begin
            state_nxt = S_LAUNCH;
            layer_nxt = cur_layer + IDX_W'(1);
          end
        end
`ifdef LAYER_SEQ_WATCHDOG_EN
        else if (wd_expired) begin
          state_nxt = S_ERROR;
        end
`endif
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
`ifdef LAYER_SEQ_WATCHDOG_EN
      S_ERROR: begin
        if (abort) begin
          state_nxt = S_IDLE;
          layer_nxt = '0;
        end else if (start) begin
          state_nxt = S_LAUNCH;
          layer_nxt = '0;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
        layer_nxt = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      layer_start <= '0;
      cur_layer   <= '0;
      run_cycles  <= '0;
    end else begin
      state       <= state_nxt;
      cur_layer   <= layer_nxt;
      busy        <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);
      done        <= (state_nxt == S_FINISH);
      layer_start <= (state_nxt == S_LAUNCH) ? (NUM_LAYERS'(1) << layer_nxt) : '0;
      if (run_accept) begin
        run_cycles <= '0;
      end else if (busy && (run_cycles != {CNT_W{1'b1}})) begin
        run_cycles <= run_cycles + CNT_W'(1);
      end
    end
  end

`ifdef LAYER_SEQ_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      err <= (state_nxt == S_ERROR);
      if (state == S_LAUNCH) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl (NUM_LAYERS=3, TIMEOUT=8); inputs and checks happen on the falling edge.
module tb_layer_seq_ctrl;

  localparam int NL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [NL-1:0] layer_start;
  logic [NL-1:0] layer_done;
  logic [1:0]    cur_layer;
  logic [15:0]   run_cycles;
  logic          err;

  logic [NL-1:0] eng_done = '0;
  logic [NL-1:0] man_done = '0;
  logic [NL-1:0] eng_mask = '1;
  int            eng_cnt [NL];

  int            n_chk = 0;
  int            n_err = 0;
  int            busy_cnt = 0;
  int            done_cnt = 0;
  logic [NL-1:0] ls_log [$];

  assign layer_done = eng_done | man_done;

  layer_seq_ctrl #(.NUM_LAYERS(3), .IDX_W(2), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .layer_start(layer_start), .layer_done(layer_done), .cur_layer(cur_layer),
    .run_cycles(run_cycles), .err(err)
  );

  always #5 clk = ~clk;

  // Engine model: pulses layer_done[i] in the third cycle after layer_start[i].
  initial begin
    for (int i = 0; i < NL; i++) eng_cnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        eng_done[i] = 1'b0;
        if (eng_cnt[i] > 0) begin
          eng_cnt[i] = eng_cnt[i] - 1;
          if (eng_cnt[i] == 0) eng_done[i] = 1'b1;
        end
        if (layer_start[i] && eng_mask[i]) eng_cnt[i] = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (layer_start != '0) ls_log.push_back(layer_start);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    busy_cnt = 0;
    done_cnt = 0;
    ls_log.delete();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_ls(input string tag, input logic [NL-1:0] pat, input int budget);
    int k;
    k = 0;
    while (layer_start != pat && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, {29'd0, layer_start}, {29'd0, pat});
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nls"}, ls_log.size(), 3);
    if (ls_log.size() == 3) begin
      check({tag, "_ls0"}, {29'd0, ls_log[0]}, 32'h1);
      check({tag, "_ls1"}, {29'd0, ls_log[1]}, 32'h2);
      check({tag, "_ls2"}, {29'd0, ls_log[2]}, 32'h4);
    end
  endtask

  task automatic do_start();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    // Reset at power-up
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ls", {29'd0, layer_start}, 0);
    check("rst_rc", {16'd0, run_cycles}, 0);

    // Normal run with 3-cycle engines
    clear_mon();
    do_start();
    check("lat_ls0", {29'd0, layer_start}, 32'h1);
    check("lat_busy", {31'd0, busy}, 1);
    check("lat_rc", {16'd0, run_cycles}, 0);
    wait_done("norm_done", 60);
    check("fin_busy", {31'd0, busy}, 0);
    check("fin_cur", {30'd0, cur_layer}, 2);
    check("fin_rc", {16'd0, run_cycles}, 12);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("fin_start_ign_ls", {29'd0, layer_start}, 0);
    check("fin_start_ign_busy", {31'd0, busy}, 0);
    check("norm_done_once", done_cnt, 1);
    check("norm_busy_cnt", busy_cnt, 12);
    check("norm_rc_hold", {16'd0, run_cycles}, 12);
    check_log("norm");

    // Spurious done on another layer and start while busy
    clear_mon();
    do_start();
    tick(1);
    man_done = 3'b100;
    start = 1'b1;
    tick(1);
    check("spur_cur", {30'd0, cur_layer}, 0);
    check("spur_busy", {31'd0, busy}, 1);
    man_done = 3'b000;
    start = 1'b0;
    wait_done("spur_done", 60);
    check("spur_rc", {16'd0, run_cycles}, 12);
    tick(2);
    check("spur_busy_cnt", busy_cnt, 12);
    check("spur_done_once", done_cnt, 1);
    check_log("spur");

    // Abort in the first WAIT cycle of layer 1
    clear_mon();
    do_start();
    wait_ls("ab_ls1", 3'b010, 20);
    tick(1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_cur", {30'd0, cur_layer}, 0);
    check("ab_done", {31'd0, done}, 0);
    check("ab_rc", {16'd0, run_cycles}, 6);
    tick(6);
    check("ab_rc_hold", {16'd0, run_cycles}, 6);
    check("ab_no_done", done_cnt, 0);
    check("ab_nls", ls_log.size(), 2);
    clear_mon();
    do_start();
    wait_done("ab_rerun_done", 60);
    check("ab_rerun_rc", {16'd0, run_cycles}, 12);
    tick(2);
    check_log("ab_rerun");

    // Layer 1 never completes
    eng_mask = 3'b101;
    clear_mon();
    do_start();
    wait_ls("wd_ls1", 3'b010, 20);
    tick(8);
    check("wd_pre_err", {31'd0, err}, 0);
    check("wd_pre_busy", {31'd0, busy}, 1);
    tick(1);
`ifdef LAYER_SEQ_WATCHDOG_EN
    check("wd_err", {31'd0, err}, 1);
    check("wd_busy", {31'd0, busy}, 0);
    check("wd_cur", {30'd0, cur_layer}, 1);
    tick(3);
    check("wd_err_sticky", {31'd0, err}, 1);
    check("wd_no_done", done_cnt, 0);
    eng_mask = 3'b111;
    clear_mon();
    do_start();
    check("wd_restart_err", {31'd0, err}, 0);
    check("wd_restart_ls0", {29'd0, layer_start}, 32'h1);
    wait_done("wd_restart_done", 60);
    check("wd_restart_rc", {16'd0, run_cycles}, 12);
`else
    check("nowd_err", {31'd0, err}, 0);
    check("nowd_busy", {31'd0, busy}, 1);
    check("nowd_cur", {30'd0, cur_layer}, 1);
    tick(20);
    check("nowd_still_busy", {31'd0, busy}, 1);
    check("nowd_still_err", {31'd0, err}, 0);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("nowd_abort", {31'd0, busy}, 0);
    eng_mask = 3'b111;
`endif
    tick(6);

    // Zero-wait engines: done held high
    eng_mask = 3'b000;
    man_done = 3'b111;
    clear_mon();
    tick(1);
    start = 1'b1;
    begin
      int k;
      k = 0;
      tick(1);
      start = 1'b0;
      k = 1;
      while (!done && k < 30) begin
        tick(1);
        k++;
      end
      check("zw_latency", k, 7);
    end
    check("zw_rc", {16'd0, run_cycles}, 6);
    tick(1);
    check("zw_busy_cnt", busy_cnt, 6);
    man_done = 3'b000;
    eng_mask = 3'b111;
    tick(2);

    // Reset in the middle of WAIT on layer 1
    clear_mon();
    do_start();
    wait_ls("rst_mid_ls1", 3'b010, 20);
    tick(1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("rstm_busy", {31'd0, busy}, 0);
    check("rstm_ls", {29'd0, layer_start}, 0);
    check("rstm_cur", {30'd0, cur_layer}, 0);
    check("rstm_rc", {16'd0, run_cycles}, 0);
    check("rstm_err", {31'd0, err}, 0);
    tick(1);
    check("rstm_ls_after", {29'd0, layer_start}, 0);
    check("rstm_done_after", {31'd0, done}, 0);
    tick(4);
    check("rstm_idle", {31'd0, busy}, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
